apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

APB completer that sits directly downstream of the team's APB master and consumes its PSEL/PENABLE/PADDR/PWDATA/PWRITE/PSTRB, returning PREADY/PRDATA/PSLVERR. It holds a bank of 32-bit byte-strobed registers with a read-only ID word at index 0. It inserts a programmable number of wait states and flags out-of-range or illegal accesses with PSLVERR.

## Interface
- DEPTH, 16: number of 32-bit words, 2..64; word index = PADDR[7:2].
- WAIT_CYCLES, 0: wait states per transfer, 0..7.
- ID_VALUE, 32'hA5B0_0001: constant returned by word 0.
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  byte address; PADDR[1:0] ignored.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte-lane write enables; ignored on reads.
- PREADY  out  1  transfer completes this cycle; registered.
- PRDATA  out  32  read data, valid only while PREADY=1; registered.
- PSLVERR  out  1  error response, valid only while PREADY=1; registered.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on PSEL=1, PENABLE=0 (setup), latch PADDR[7:2], PWRITE, PWDATA, PSTRB, load wait counter = WAIT_CYCLES.
  - If WAIT_CYCLES=0, go to RESP. Else go to WAIT.
  - PENABLE=1 seen in IDLE without a prior setup is ignored.
- WAIT: decrement counter each cycle while PSEL=1. On the edge where the counter reaches 0, go to RESP.
- RESP: PREADY=1. Transfer completes on the edge with PSEL=PENABLE=PREADY=1. Then return to IDLE, and PREADY drops the next cycle.
  - A setup phase present in that same cycle is not accepted. The master's next SETUP is sampled from IDLE.
- Abort: PSEL=0 in WAIT or RESP sends the block to IDLE. No write, PREADY=0.
- Error (PSLVERR=1 with PREADY) occurs when:
  - word index >= DEPTH; or
  - a write to word 0.
  - On error: no storage change, PRDATA=0.
- Write: on the completing edge, for each lane i with PSTRB[i]=1, reg[idx][8i+7:8i] <= PWDATA lane. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read: PRDATA = reg[idx] (ID_VALUE for idx 0), loaded on the edge entering RESP. PRDATA is 0 in every non-RESP cycle.
- PSLVERR is computed from the latched address and direction, and is only nonzero in RESP.

## Timing
- Reset (PRESET=0, async) forces:
  - state IDLE, counter 0;
  - PREADY=0, PRDATA=0, PSLVERR=0;
  - all writable words = 0.
  - Release is synchronous to PCLK. Assertion mid-transfer drops PREADY immediately and discards the transfer.
- Setup in cycle T: PREADY=1 in cycle T+1+WAIT_CYCLES. A master holding PENABLE sees exactly WAIT_CYCLES cycles of PREADY=0.
- Back-to-back: completion at T+1 (WAIT_CYCLES=0), IDLE at T+2, next setup at T+2, next completion at T+3. Minimum 2 cycles per transfer.
- Write data is visible to a read whose RESP cycle follows the completing edge. No bypass is needed.
- Address/data changes after the setup cycle are ignored; latched values are used.

## Structure
- Package apb_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - APB_ADDR_W=8, APB_DATA_W=32, APB_STRB_W=4;
  - ID word index constant 0.
- Sub-module apb_reg_array: DEPTH x 32 storage, per-byte write enable, asynchronous read, async active-low clear. The FSM, counter and response logic stay in apb_regfile_slave.

## Test plan
- Reset then read idx 0 (PADDR=8'h00), WAIT_CYCLES=0 -> PREADY in T+1, PRDATA=32'hA5B0_0001, PSLVERR=0; after reset, idx 3 reads 0.
- Write PADDR=8'h0C, PWDATA=32'h1122_3344, PSTRB=4'b0101, then read 8'h0C -> 32'h0022_0044.
- WAIT_CYCLES=3, read 8'h04 -> exactly 3 cycles of PENABLE=1 with PREADY=0, then PREADY=1 for one cycle.
- Write to 8'h00 and read PADDR=8'h40 (idx 16, DEPTH=16) -> PSLVERR=1 with PREADY, PRDATA=0, no storage change.
- WAIT_CYCLES=5, drop PSEL in 2nd wait cycle of a write to 8'h08 -> no PREADY, word 2 unchanged; assert PRESET=0 mid-WAIT -> PREADY/PRDATA/PSLVERR=0 at once.

Source files
------------

// File: rtl/apb_regfile_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_pkg : shared APB widths, FSM state type and ID word index       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int ID_IDX     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_reg_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_reg_array : DEPTH x 32 storage, byte write enables, async read  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module apb_reg_array
  import apb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [APB_STRB_W-1:0] i_we,
  input  logic [APB_DATA_W-1:0] i_wdata,
  output logic [APB_DATA_W-1:0] o_rdata
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = ADDR_W + 1;

  logic [APB_DATA_W-1:0] r_mem [DEPTH];
  logic                  w_in_range;
  logic [AW-1:0]         w_word;

  always_comb begin
    w_in_range = ({1'b0, i_addr} < CMP_W'(DEPTH));
    w_word     = i_addr[AW-1:0];
    o_rdata    = w_in_range ? r_mem[w_word] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_in_range) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (i_we[b]) begin
          r_mem[w_word][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_regfile_slave : APB completer, byte-strobed regs, wait states  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  output logic                  PREADY,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int         IDX_W       = APB_ADDR_W - 2;
  localparam int         CMP_W       = IDX_W + 1;
  localparam logic [2:0] C_WAIT_LOAD = 3'(WAIT_CYCLES);

  apb_state_e            r_state, w_state_nxt;
  logic [2:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx, w_idx_sel;
  logic                  r_write, w_write_sel;
  logic [APB_DATA_W-1:0] r_wdata;
  logic [APB_STRB_W-1:0] r_strb, w_we;
  logic                  r_pready, r_pslverr;
  logic [APB_DATA_W-1:0] r_prdata;
  logic                  w_setup, w_err, w_complete;
  logic [APB_DATA_W-1:0] w_arr_rdata, w_rd_word;

  // With zero wait states RESP is entered straight from setup, so the
  // response must be computed from the live bus rather than the latches.
  always_comb begin
    w_setup     = (r_state == ST_IDLE) && PSEL && !PENABLE;
    w_idx_sel   = w_setup ? PADDR[APB_ADDR_W-1:2] : r_idx;
    w_write_sel = w_setup ? PWRITE : r_write;
    w_err       = ({1'b0, w_idx_sel} >= CMP_W'(DEPTH)) ||
                  (w_write_sel && (w_idx_sel == IDX_W'(ID_IDX)));
    w_rd_word   = (w_idx_sel == IDX_W'(ID_IDX)) ? ID_VALUE : w_arr_rdata;
    w_complete  = (r_state == ST_RESP) && PSEL && PENABLE;
    w_we        = (w_complete && r_write && !r_pslverr) ? r_strb : '0;

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_setup) w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!PSEL)                w_state_nxt = ST_IDLE;
        else if (r_cnt == 3'd1)   w_state_nxt = ST_RESP;
      end
      ST_RESP: if (!PSEL || PENABLE) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_setup) begin
        r_idx   <= PADDR[APB_ADDR_W-1:2];
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_strb  <= PSTRB;
        r_cnt   <= C_WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && PSEL) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_state_nxt == ST_RESP) begin
        r_pready <= 1'b1;
        if (r_state != ST_RESP) begin
          r_pslverr <= w_err;
          r_prdata  <= (w_err || w_write_sel) ? '0 : w_rd_word;
        end
      end else begin
        r_pready  <= 1'b0;
        r_prdata  <= '0;
        r_pslverr <= 1'b0;
      end
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

  apb_reg_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_array (
    .i_clk   (PCLK),
    .i_rst_n (PRESET),
    .i_addr  (w_idx_sel),
    .i_we    (w_we),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_regfile_slave : three completers (0/3/5 wait states) vs model|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_apb_regfile_slave;

  localparam logic [31:0] C_ID = 32'hA5B0_0001;

  int wts [3] = '{0, 3, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       preset  = '0;
  logic [2:0]       psel    = '0;
  logic [2:0]       penable = '0;
  logic [2:0]       pwrite  = '0;
  logic [2:0][7:0]  paddr   = '0;
  logic [2:0][31:0] pwdata  = '0;
  logic [2:0][3:0]  pstrb   = '0;
  logic [2:0]       pready;
  logic [2:0][31:0] prdata;
  logic [2:0]       pslverr;

  logic [31:0] mem [3][16];
  logic        exp_pready [3];
  logic [31:0] exp_prdata [3];
  logic        exp_pslverr[3];
  bit          exp_chkd   [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_regfile_slave #(
      .DEPTH       (16),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
      .ID_VALUE    (C_ID)
    ) u_dut (
      .PCLK    (clk),
      .PRESET  (preset[g]),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PSTRB   (pstrb[g]),
      .PREADY  (pready[g]),
      .PRDATA  (prdata[g]),
      .PSLVERR (pslverr[g])
    );
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, expv);
    end
  endtask

  task automatic set_exp(input int d, input logic rdy, input logic [31:0] rdv, input logic sl, input bit chk);
    exp_pready[d]  = rdy;
    exp_prdata[d]  = rdv;
    exp_pslverr[d] = sl;
    exp_chkd[d]    = chk;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check("pready", d, {31'b0, pready[d]}, {31'b0, exp_pready[d]});
      check("pslverr", d, {31'b0, pslverr[d]}, {31'b0, exp_pslverr[d]});
      if (exp_chkd[d]) check("prdata", d, prdata[d], exp_prdata[d]);
    end
  end

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
    end
  endtask

  // Access phase with no preceding setup: must be ignored.
  task automatic stray(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b0; paddr[d] = 8'h00;
    set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    idle(d, 1);
  endtask

  // mode 0: normal, 1: drop PSEL in access cycle 'at', 2: assert reset in access cycle 'at'
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input int mode, input int at,
                      output logic [31:0] rd, output logic slv, output int nwait);
    int          w;
    logic [5:0]  idx;
    logic        e;
    logic [31:0] erd;
    w     = wts[d];
    idx   = addr[7:2];
    e     = (idx >= 6'd16) || (wr && (idx == 6'd0));
    erd   = (e || wr) ? 32'h0 : ((idx == 6'd0) ? C_ID : mem[d][idx[3:0]]);
    rd    = 32'h0;
    slv   = 1'b0;
    nwait = 0;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wd; pstrb[d] = strb;
    set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      penable[d] = 1'b1;
      paddr[d]   = addr ^ 8'h04;
      pwdata[d]  = ~wd;
      pstrb[d]   = ~strb;
      if (k == w) set_exp(d, 1'b1, erd, e, !wr);
      else        set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
      if (mode == 1 && k == at) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        return;
      end
      if (mode == 2 && k == at) begin
        #2;
        preset[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
        set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
        #1;
        check("rst_pready", d, {31'b0, pready[d]}, 32'h0);
        check("rst_prdata", d, prdata[d], 32'h0);
        check("rst_pslverr", d, {31'b0, pslverr[d]}, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        preset[d] = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      if (pready[d] === 1'b1) begin
        rd  = prdata[d];
        slv = pslverr[d];
      end else begin
        nwait++;
      end
    end
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[d][idx[3:0]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        slv;
    int          nw;
    for (int d = 0; d < 3; d++) begin
      set_exp(d, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 preset = '1;

    // Zero wait states: ID read, reset contents, strobed writes, errors
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("id_rd", 0, rd, C_ID);
    check("id_slv", 0, {31'b0, slv}, 32'h0);
    check("id_wait", 0, 32'(nw), 32'd0);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("idx3_rst", 0, rd, 32'h0);
    xfer(0, 1, 8'h0C, 32'h1122_3344, 4'b0101, 0, 0, rd, slv, nw);
    check("wr_slv", 0, {31'b0, slv}, 32'h0);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("strb_rd", 0, rd, 32'h0022_0044);
    xfer(0, 1, 8'h0C, 32'hFFFF_FFFF, 4'b0000, 0, 0, rd, slv, nw);
    check("nostrb_slv", 0, {31'b0, slv}, 32'h0);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("nostrb_rd", 0, rd, 32'h0022_0044);
    stray(0);
    xfer(0, 1, 8'h00, 32'hDEAD_0000, 4'hF, 0, 0, rd, slv, nw);
    check("wr_id_slv", 0, {31'b0, slv}, 32'h1);
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("id_kept", 0, rd, C_ID);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("oor_slv", 0, {31'b0, slv}, 32'h1);
    check("oor_rd", 0, rd, 32'h0);
    xfer(0, 0, 8'hFC, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("oor63_slv", 0, {31'b0, slv}, 32'h1);
    idle(0, 1);

    // Three wait states, top valid word, reset while in RESP
    xfer(1, 0, 8'h04, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("w3_wait", 1, 32'(nw), 32'd3);
    check("w3_rd", 1, rd, 32'h0);
    xfer(1, 1, 8'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, slv, nw);
    xfer(1, 0, 8'h3C, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("w3_top_rd", 1, rd, 32'hDEAD_BEEF);
    check("w3_top_wait", 1, 32'(nw), 32'd3);
    xfer(1, 0, 8'h3C, 32'h0, 4'h0, 2, 3, rd, slv, nw);
    idle(1, 1);
    xfer(1, 0, 8'h3C, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("w3_cleared", 1, rd, 32'h0);
    idle(1, 1);

    // Five wait states: abort keeps old data, reset mid-WAIT clears it
    xfer(2, 1, 8'h08, 32'h55AA_55AA, 4'hF, 0, 0, rd, slv, nw);
    xfer(2, 1, 8'h08, 32'h1234_5678, 4'hF, 1, 1, rd, slv, nw);
    idle(2, 2);
    xfer(2, 0, 8'h08, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("abort_rd", 2, rd, 32'h55AA_55AA);
    check("w5_wait", 2, 32'(nw), 32'd5);
    xfer(2, 1, 8'h10, 32'h0000_0ABC, 4'hF, 2, 2, rd, slv, nw);
    idle(2, 1);
    xfer(2, 0, 8'h08, 32'h0, 4'h0, 0, 0, rd, slv, nw);
    check("w5_cleared", 2, rd, 32'h0);
    idle(2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
